// File: rtl/xilinx_distram_fifo_if.sv
// Valid/ready bus for xilinx_distram_fifo.
// Write side: WR_VALID/WR_READY/WR_DATA. Read side: RD_VALID/RD_READY/RD_DATA.
// Status: COUNT, ALMOST_FULL, ALMOST_EMPTY, OVERFLOW.
interface xilinx_distram_fifo_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6
);
  logic                  WR_VALID;
  logic                  WR_READY;
  logic [DATA_WIDTH-1:0] WR_DATA;
  logic                  RD_VALID;
  logic                  RD_READY;
  logic [DATA_WIDTH-1:0] RD_DATA;
  logic [ADDR_WIDTH:0]   COUNT;
  logic                  ALMOST_FULL;
  logic                  ALMOST_EMPTY;
  logic                  OVERFLOW;

  modport slave (
    input  WR_VALID, WR_DATA, RD_READY,
    output WR_READY, RD_VALID, RD_DATA,
    output COUNT, ALMOST_FULL, ALMOST_EMPTY,
    output OVERFLOW
  );

  modport master (
    output WR_VALID, WR_DATA, RD_READY,
    input  WR_READY, RD_VALID, RD_DATA,
    input  COUNT, ALMOST_FULL, ALMOST_EMPTY,
    input  OVERFLOW
  );
endinterface

// File: rtl/xilinx_distram_fifo.sv
// Sync FIFO on dual-port distributed RAM (write on A, read on DPRA).
// Ports: WCLK, RSTN (sync, active-low), bus (xilinx_distram_fifo_if.slave).
// Macro XILINX_DISTRAM_FIFO_OREG_EN adds a registered output stage.
module xilinx_distram_fifo #(
  parameter int ADDR_WIDTH    = 6,
  parameter int DATA_WIDTH    = 8,
  parameter int AFULL_THRESH  = (1 << ADDR_WIDTH) - 4,
  parameter int AEMPTY_THRESH = 4
) (
  input  logic                  WCLK,
  input  logic                  RSTN,
  xilinx_distram_fifo_if.slave  bus
);
  localparam int AW = ADDR_WIDTH;
  localparam int DW = DATA_WIDTH;
  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE = (AW+1)'(1);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   ram_cnt_q, ram_cnt_d;
  logic          ovf_q, ovf_d;

  logic          wr_ready;
  logic          wr_en;
  logic          rd_valid;
  logic          rd_acc;
  logic          ram_pop;
  logic [AW:0]   count;
  logic [DW-1:0] rd_data;
  logic [DW-1:0] dpo;

  // Distributed RAM: one column per data bit,
  // small depths map to RAM32X1D / RAM64X1D.
  if (AW <= 6) begin : g_lut
    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge WCLK) begin
      if (wr_en) mem[wr_ptr_q] <= bus.WR_DATA;
    end

    assign dpo = mem[rd_ptr_q];
  end else begin : g_bank
    // Banks of 128 entries (RAM128X1D); upper
    // address bits gate WE and select DPO.
    localparam int NB = 1 << (AW - 7);
    localparam int HB = (AW > 7) ? AW - 7 : 1;

    logic [HB-1:0] wsel;
    logic [HB-1:0] rsel;
    logic [DW-1:0] bank_dpo [NB];

    assign wsel = HB'(wr_ptr_q >> 7);
    assign rsel = HB'(rd_ptr_q >> 7);

    for (genvar b = 0; b < NB; b++) begin : g_col
      logic [DW-1:0] mem [128];
      logic          bank_we;

      assign bank_we = wr_en && (wsel == HB'(b));

      always_ff @(posedge WCLK) begin
        if (bank_we) mem[wr_ptr_q[6:0]] <= bus.WR_DATA;
      end

      assign bank_dpo[b] = mem[rd_ptr_q[6:0]];
    end

    always_comb begin
      dpo = '0;
      for (int b = 0; b < NB; b++) begin
        if (rsel == HB'(b)) dpo = bank_dpo[b];
      end
    end
  end

  // Ready depends only on RAM occupancy, so a
  // read never frees a slot in the same cycle.
  assign wr_ready = RSTN && (ram_cnt_q != FULL_CNT);
  assign wr_en    = bus.WR_VALID && wr_ready;

`ifdef XILINX_DISTRAM_FIFO_OREG_EN
  logic          oreg_v_q, oreg_v_d;
  logic [DW-1:0] oreg_q, oreg_d;
  logic [AW:0]   count_q, count_d;

  assign rd_valid = oreg_v_q;
  assign rd_acc   = oreg_v_q && bus.RD_READY;
  // Load when the register is empty, or refill
  // on the edge it is being popped.
  assign ram_pop  = (ram_cnt_q != '0) &&
                    (!oreg_v_q || bus.RD_READY);

  always_comb begin
    oreg_v_d = oreg_v_q;
    oreg_d   = oreg_q;
    unique case (1'b1)
      ram_pop: begin
        oreg_v_d = 1'b1;
        oreg_d   = dpo;
      end
      rd_acc: begin
        oreg_v_d = 1'b0;
        oreg_d   = '0;
      end
      default: ;
    endcase
  end

  always_comb begin
    count_d = ram_cnt_d + {{AW{1'b0}}, oreg_v_d};
  end

  always_ff @(posedge WCLK) begin
    if (!RSTN) begin
      oreg_v_q <= 1'b0;
      oreg_q   <= '0;
      count_q  <= '0;
    end else begin
      oreg_v_q <= oreg_v_d;
      oreg_q   <= oreg_d;
      count_q  <= count_d;
    end
  end

  assign count   = count_q;
  assign rd_data = oreg_q;
`else
  assign rd_valid = (ram_cnt_q != '0);
  assign rd_acc   = rd_valid && bus.RD_READY;
  assign ram_pop  = rd_acc;
  assign count    = ram_cnt_q;
  assign rd_data  = dpo;
`endif

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    ram_cnt_d = ram_cnt_q;
    if (wr_en)   wr_ptr_d = wr_ptr_q + 1'b1;
    if (ram_pop) rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({wr_en, ram_pop})
      2'b10:   ram_cnt_d = ram_cnt_q + ONE;
      2'b01:   ram_cnt_d = ram_cnt_q - ONE;
      default: ram_cnt_d = ram_cnt_q;
    endcase
  end

  always_comb begin
    ovf_d = ovf_q | (bus.WR_VALID && !wr_ready);
  end

  always_ff @(posedge WCLK) begin
    if (!RSTN) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      ram_cnt_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      ram_cnt_q <= ram_cnt_d;
      ovf_q     <= ovf_d;
    end
  end

  assign bus.WR_READY     = wr_ready;
  assign bus.RD_VALID     = rd_valid;
  assign bus.RD_DATA      = rd_data;
  assign bus.COUNT        = count;
  assign bus.OVERFLOW     = ovf_q;
  assign bus.ALMOST_FULL  = int'(count) >= AFULL_THRESH;
  assign bus.ALMOST_EMPTY = int'(count) <= AEMPTY_THRESH;
endmodule
